wb_byte_pipe: RTL

- Wishbone responder on the NEORV32 bus (clk_neo domain) that forms the firmware-side end of the byte link to the PCIe-side fake 16550A.
- Software writes bytes into a TX FIFO. The block drains them as single-cycle valid strobes into the neo-to-PCIe handshake CDC, paced to the CDC round-trip.
- Bytes arriving as strobes from the PCIe-to-neo CDC land in an RX FIFO readable by software. Status, flush and interrupt are provided.

---
 rtl/wb_byte_pipe.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_byte_pipe.sv
// wb_byte_pipe: Wishbone byte pipe between firmware and the PCIe-side UART CDC.
// TX FIFO drains as paced single-cycle strobes; RX strobes fill a readable FIFO.
// Optional build macro WB_BYTE_PIPE_LOOPBACK_EN adds CTRL bit3 LOOPBACK (TX -> RX).
module wb_byte_pipe #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_2000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          TX_GAP     = 16
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(TX_GAP) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} tx_state_t;

  logic            ack_q, err_q, req_we, req_sel0;
  logic [1:0]      req_reg;
  logic [7:0]      req_dat;
  logic            hit, off_ok;
  logic            data_wr, data_rd, stat_wr, ctrl_wr, flush;
  logic            rx_ie, tx_ie, rx_ovf, tx_drop, irq_q;
  logic [7:0]      tx_mem [FIFO_DEPTH];
  logic [7:0]      rx_mem [FIFO_DEPTH];
  logic [AW-1:0]   tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]   tx_count, rx_count;
  logic            tx_full, tx_empty, rx_full, rx_empty, tx_idle;
  logic            tx_push, tx_pop, rx_push, rx_pop, rx_ovf_set;
  logic            rx_in_valid;
  logic [7:0]      rx_in_data, tx_head, rx_head, tx_hold;
  logic            send;
  tx_state_t       state, state_n;
  logic [GW-1:0]   gap_cnt, gap_n;
  logic [31:0]     rdata;
  logic            unused_sel;

  assign unused_sel = ^wb_sel_i[3:1];

  // A bus hit is ignored while this block is still answering the previous one.
  assign hit    = wb_cyc_i & wb_stb_i & (wb_adr_i[31:12] == BASE_ADDR[31:12]) & ~(ack_q | err_q);
  assign off_ok = (wb_adr_i[11:0] == 12'h000) | (wb_adr_i[11:0] == 12'h004) |
                  (wb_adr_i[11:0] == 12'h008);

  assign data_wr = ack_q & req_we & (req_reg == 2'd0) & req_sel0;
  assign data_rd = ack_q & ~req_we & (req_reg == 2'd0);
  assign stat_wr = ack_q & req_we & (req_reg == 2'd1);
  assign ctrl_wr = ack_q & req_we & (req_reg == 2'd2);
  assign flush   = ctrl_wr & req_dat[2];

  assign tx_full  = (tx_count == DEPTH_C);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == DEPTH_C);
  assign rx_empty = (rx_count == '0);
  assign tx_head  = tx_mem[tx_rp];
  assign rx_head  = rx_mem[rx_rp];
  assign send     = (state == S_SEND);
  assign tx_idle  = tx_empty & (state == S_IDLE);

  assign tx_push    = data_wr & ~tx_full;
  assign tx_pop     = send & ~tx_empty;
  assign rx_pop     = data_rd & ~rx_empty;
  assign rx_push    = rx_in_valid & (~rx_full | rx_pop);
  assign rx_ovf_set = rx_in_valid & rx_full & ~rx_pop;

`ifdef WB_BYTE_PIPE_LOOPBACK_EN
  logic ctrl_loop;
  assign rx_in_valid = ctrl_loop ? tx_pop : rx_valid_i;
  assign rx_in_data  = ctrl_loop ? tx_head : rx_data_i;
  assign tx_valid_o  = send & ~ctrl_loop;
  // Loopback enable lives in its own register so the default build has none of it.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i)      ctrl_loop <= 1'b0;
    else if (ctrl_wr) ctrl_loop <= req_dat[3];
  end
`else
  logic ctrl_loop;
  assign ctrl_loop   = 1'b0;
  assign rx_in_valid = rx_valid_i;
  assign rx_in_data  = rx_data_i;
  assign tx_valid_o  = send;
`endif

  assign tx_data_o = tx_valid_o ? tx_head : tx_hold;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wb_dat_o  = (ack_q & ~req_we) ? rdata : 32'h0;
  assign irq_o     = irq_q;

  // Capture the request on a hit and answer with ack or err one cycle later.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      ack_q <= 1'b0; err_q <= 1'b0; req_we <= 1'b0; req_sel0 <= 1'b0;
      req_reg <= 2'd0; req_dat <= 8'h0;
    end else begin
      ack_q <= hit & off_ok;
      err_q <= hit & ~off_ok;
      if (hit) begin
        req_we <= wb_we_i; req_sel0 <= wb_sel_i[0];
        req_reg <= wb_adr_i[3:2]; req_dat <= wb_dat_i[7:0];
      end
    end
  end

  // Control bits, sticky error flags (a new event beats a same-cycle clear) and irq.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_ie <= 1'b0; tx_ie <= 1'b0; rx_ovf <= 1'b0; tx_drop <= 1'b0; irq_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rx_ie <= req_dat[0];
        tx_ie <= req_dat[1];
      end
      rx_ovf  <= (rx_ovf & ~(stat_wr & req_dat[3])) | (rx_ovf_set & ~flush);
      tx_drop <= (tx_drop & ~(stat_wr & req_dat[4])) | (data_wr & tx_full);
      irq_q   <= (rx_ie & ~rx_empty) | (tx_ie & tx_idle);
    end
  end

  // TX FIFO pointers and count; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_wp <= '0; tx_rp <= '0; tx_count <= '0;
    end else if (flush) begin
      tx_wp <= '0; tx_rp <= '0; tx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: ;
      endcase
    end
  end

  // RX FIFO pointers and count; a pop frees the slot for a same-cycle push.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_wp <= '0; rx_rp <= '0; rx_count <= '0;
    end else if (flush) begin
      rx_wp <= '0; rx_rp <= '0; rx_count <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage arrays carry no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= req_dat;
    if (rx_push) rx_mem[rx_wp] <= rx_in_data;
  end

  // TX state register, gap counter and the held copy of the last sent byte.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= S_IDLE; gap_cnt <= '0; tx_hold <= 8'h0;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_n;
      if (tx_valid_o) tx_hold <= tx_head;
    end
  end

  // TX next state: GAP exits as the counter reaches zero so strobes land TX_GAP apart.
  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    case (state)
      S_IDLE: if (!tx_empty && !flush) state_n = S_SEND;
      S_SEND: begin
        gap_n   = GW'(TX_GAP - 2);
        state_n = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt != '0) gap_n = gap_cnt - GW'(1);
        if (gap_cnt <= GW'(1)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Read data for the access being acknowledged this cycle.
  always_comb begin
    rdata = 32'h0;
    case (req_reg)
      2'd0: if (!rx_empty) rdata = {23'h0, 1'b1, rx_head};
      2'd1: rdata = {8'h0, 8'(tx_count), 8'(rx_count), 3'b000,
                     tx_drop, rx_ovf, tx_idle, tx_full, ~rx_empty};
      2'd2: rdata = {28'h0, ctrl_loop, 1'b0, tx_ie, rx_ie};
      default: rdata = 32'h0;
    endcase
  end

endmodule
